// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first on x,
// with optional repeats separated by an idle gap.
module seq_generator #(
    parameter int PAT_W   = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] sh_q, sh_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [PAT_W-1:0] al;
    logic [LEN_W-1:0] sa;
    logic             len_ok;

    // Left-align the pattern so the first bit always sits in the MSB.
    assign sa     = LEN_W'(PAT_W) - len;
    assign al     = pattern << sa;
    assign len_ok = (len != '0) && (len <= LEN_W'(PAT_W));

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        len_d   = len_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        fs_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        pat_d   = al;
                        len_d   = len;
                        rep_d   = reps;
                        sh_d    = al << 1;
                        bit_d   = len - LEN_W'(1);
                        x_d     = al[PAT_W-1];
                        xv_d    = 1'b1;
                        fs_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (bit_q != '0) begin
                    x_d   = sh_q[PAT_W-1];
                    xv_d  = 1'b1;
                    sh_d  = sh_q << 1;
                    bit_d = bit_q - LEN_W'(1);
                end else if (rep_q != '0) begin
                    rep_d = rep_q - CNT_W'(1);
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                        gap_d   = GW'(GAP_CYC - 1);
                    end else begin
                        x_d   = pat_q[PAT_W-1];
                        xv_d  = 1'b1;
                        fs_d  = 1'b1;
                        sh_d  = pat_q << 1;
                        bit_d = len_q - LEN_W'(1);
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    x_d     = pat_q[PAT_W-1];
                    xv_d    = 1'b1;
                    fs_d    = 1'b1;
                    sh_d    = pat_q << 1;
                    bit_d   = len_q - LEN_W'(1);
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            x_d     = 1'b0;
            xv_d    = 1'b0;
            fs_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign x           = x_q;
    assign x_valid     = xv_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
